// File: rtl/hsid_loop_fifo.sv
// hsid_loop_fifo
//   Single-clock sample FIFO for the HSID pixel/band datapath. Supports any
//   depth (including non-power-of-two), registered read data with a valid
//   strobe, simultaneous read+write when full, a counted loop (recirculate)
//   mode with a pass-complete pulse, and almost-full / almost-empty flags.
//
//   Optional feature macro: HSID_FIFO_ERR_FLAGS_EN
//     defined     -> sticky overflow/underflow flags, cleared by reset/clear
//     not defined -> overflow/underflow tied to 0, no error logic
//
// Ports
//   clk                    in  clock, rising edge
//   rst_n                  in  asynchronous active-low reset
//   clear                  in  synchronous flush (highest priority after reset)
//   wr_en / data_in        in  write request and data
//   rd_en                  in  read request (pop, or recirculate in loop mode)
//   loop_en                in  loop mode: accepted reads write head back to tail
//   almost_full_threshold  in  almost_full level, 0 disables
//   almost_empty_threshold in  almost_empty level
//   data_out / data_valid  out registered read data and its 1-cycle strobe
//   count                  out occupancy 0..FIFO_DEPTH
//   full / empty           out occupancy flags
//   almost_full/_empty     out threshold flags
//   loop_done              out 1-cycle pulse when a full rotation completes
//   overflow / underflow   out sticky error flags
module hsid_loop_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  loop_en,
  input  logic [CNT_WIDTH-1:0]  almost_full_threshold,
  input  logic [CNT_WIDTH-1:0]  almost_empty_threshold,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  loop_done,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0] PTR_ZERO  = {PTR_WIDTH{1'b0}};
  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_DEPTH = CNT_WIDTH'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr_r;
  logic [PTR_WIDTH-1:0]  wr_ptr_r;
  logic [CNT_WIDTH-1:0]  count_r;
  logic [CNT_WIDTH-1:0]  rot_cnt_r;
  logic [CNT_WIDTH-1:0]  count_nxt_s;

  logic                  full_s;
  logic                  empty_s;
  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic                  mem_we_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic                  loop_last_s;

  // Explicit wrap so any depth works without power-of-two masking.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    ptr_inc = (p == PTR_LAST) ? PTR_ZERO : (p + PTR_ONE);
  endfunction

  assign full_s       = (count_r == CNT_DEPTH);
  assign empty_s      = (count_r == CNT_ZERO);
  assign count        = count_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (almost_full_threshold != CNT_ZERO) && (count_r >= almost_full_threshold);
  assign almost_empty = (count_r <= almost_empty_threshold);

  assign head_s   = mem_r[rd_ptr_r];
  assign rd_acc_s = rd_en && !empty_s;
  // In loop mode external writes are never accepted; the recirculation
  // write is driven separately through mem_we_s.
  assign wr_acc_s = !loop_en && wr_en && (!full_s || rd_acc_s);
  assign mem_we_s    = wr_acc_s || (loop_en && rd_acc_s);
  assign mem_wdata_s = loop_en ? head_s : data_in;
  // Last entry of the current rotation; only meaningful when count_r != 0.
  assign loop_last_s = (rot_cnt_r == (count_r - CNT_ONE));

  // Next occupancy: loop mode recirculates so occupancy holds.
  always_comb begin
    count_nxt_s = count_r;
    if (loop_en) begin
      count_nxt_s = count_r;
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care after reset/clear.
  always_ff @(posedge clk) begin
    if (mem_we_s && !clear) begin
      mem_r[wr_ptr_r] <= mem_wdata_s;
    end
  end

  // Pointers, occupancy, rotation counter and registered read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      rot_cnt_r  <= CNT_ZERO;
      data_out   <= {DATA_WIDTH{1'b0}};
      data_valid <= 1'b0;
      loop_done  <= 1'b0;
    end else if (clear) begin
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      rot_cnt_r  <= CNT_ZERO;
      data_out   <= {DATA_WIDTH{1'b0}};
      data_valid <= 1'b0;
      loop_done  <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      data_valid <= rd_acc_s;
      if (rd_acc_s) begin
        data_out <= head_s;
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        data_out <= data_out;
        rd_ptr_r <= rd_ptr_r;
      end
      if (mem_we_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      // Rotation tracking only lives while loop mode is held.
      if (!loop_en) begin
        rot_cnt_r <= CNT_ZERO;
        loop_done <= 1'b0;
      end else if (rd_acc_s && loop_last_s) begin
        rot_cnt_r <= CNT_ZERO;
        loop_done <= 1'b1;
      end else if (rd_acc_s) begin
        rot_cnt_r <= rot_cnt_r + CNT_ONE;
        loop_done <= 1'b0;
      end else begin
        rot_cnt_r <= rot_cnt_r;
        loop_done <= 1'b0;
      end
    end
  end

`ifdef HSID_FIFO_ERR_FLAGS_EN
  logic overflow_ev_s;
  logic underflow_ev_s;

  // A rejected write covers both "full without read" and "any write in loop mode".
  assign overflow_ev_s  = wr_en && !wr_acc_s;
  assign underflow_ev_s = rd_en && empty_s;

  // Sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow  | overflow_ev_s;
      underflow <= underflow | underflow_ev_s;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_hsid_loop_fifo.sv
module tb_hsid_loop_fifo;

  localparam int DW = 16;
  localparam int D  = 5;
  localparam int CW = $clog2(D + 1);
`ifdef HSID_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic          loop_en = 1'b0;
  logic [CW-1:0] af_thr = 3'd4;
  logic [CW-1:0] ae_thr = 3'd1;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [CW-1:0] count;
  logic          full, empty, almost_full, almost_empty, loop_done, overflow, underflow;

  hsid_loop_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .loop_en(loop_en),
    .almost_full_threshold(af_thr), .almost_empty_threshold(ae_thr),
    .data_out(data_out), .data_valid(data_valid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .loop_done(loop_done), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          c;
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic          l;
    int            cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  // reference model state
  int   mdl[$];
  int   sb[$];
  int   mrot = 0;
  int   exp_dout = 0;
  bit   mov = 0;
  bit   mun = 0;
  bit   exp_v = 0;
  bit   exp_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic add(input logic c, input logic w, input int d, input logic r, input logic l, input int cnt);
    vec_t v;
    v.c = c; v.w = w; v.d = DW'(d); v.r = r; v.l = l; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    mdl.delete(); sb.delete();
    mrot = 0; exp_dout = 0; mov = 0; mun = 0;
  endtask

  task automatic check_outputs();
    int n;
    n = mdl.size();
    chk("data_valid", int'(data_valid), int'(exp_v));
    if (exp_v) begin
      if (sb.size() == 0) chk("sb_underrun", 1, 0);
      else exp_dout = sb.pop_front();
    end
    chk("data_out", int'(data_out), exp_dout);
    chk("count", int'(count), n);
    chk("full", int'(full), int'(n == D));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(almost_full), int'(af_thr != 0 && n >= int'(af_thr)));
    chk("almost_empty", int'(almost_empty), int'(n <= int'(ae_thr)));
    chk("loop_done", int'(loop_done), int'(exp_done));
    chk("overflow", int'(overflow), int'(mov & ERR_EN));
    chk("underflow", int'(underflow), int'(mun & ERR_EN));
  endtask

  // Called at a negedge: drive one cycle, update model, check at the next negedge.
  task automatic cycle(input logic c, input logic w, input logic [DW-1:0] d, input logic r, input logic l);
    int n;
    int v;
    bit ra, wa;
    clear = c; wr_en = w; data_in = d; rd_en = r; loop_en = l;
    exp_v = 0; exp_done = 0;
    n = mdl.size();
    if (c) begin
      model_reset();
    end else if (l) begin
      if (w) mov = 1;
      if (r && n == 0) mun = 1;
      if (r && n > 0) begin
        v = mdl.pop_front();
        mdl.push_back(v);
        sb.push_back(v);
        exp_v = 1;
        if (mrot == n - 1) begin exp_done = 1; mrot = 0; end
        else mrot++;
      end
    end else begin
      mrot = 0;
      ra = r && (n > 0);
      wa = w && ((n < D) || ra);
      if (w && !wa) mov = 1;
      if (r && n == 0) mun = 1;
      if (ra) begin
        sb.push_back(mdl.pop_front());
        exp_v = 1;
      end
      if (wa) mdl.push_back(int'(d));
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    // --- vector table ---
    // 1: fill to full, overflow write, drain in order
    for (int i = 1; i <= 5; i++) add(0, 1, i, 0, 0, i);
    add(0, 1, 6, 0, 0, 5);
    for (int i = 4; i >= 0; i--) add(0, 0, 0, 1, 0, i);
    // 2: full + simultaneous read/write, then drain across the wrap
    for (int i = 1; i <= 5; i++) add(0, 1, i, 0, 0, i);
    add(0, 1, 9, 1, 0, 5);
    for (int i = 4; i >= 0; i--) add(0, 0, 0, 1, 0, i);
    // 3: empty + read/write -> write only
    add(0, 1, 7, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0);
    // 4: loop mode rotation of 3 entries, write in loop mode is rejected
    add(0, 1, 3, 0, 0, 1);
    add(0, 1, 4, 0, 0, 2);
    add(0, 1, 5, 0, 0, 3);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 1, 3);
    add(0, 1, 8, 0, 1, 3);
    add(0, 0, 0, 1, 1, 3);

    // --- reset ---
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].c, vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].l);
      chk($sformatf("tbl_count[%0d]", i), int'(count), vecs[i].cnt);
    end

    // Re-entering loop mode restarts the rotation: one more read then exit/re-enter.
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1);

    // 6a: async reset mid-loop with count=3
    cycle(0, 0, 0, 1, 1);
    rd_en = 1'b1; loop_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_loop_done", int'(loop_done), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_underflow", int'(underflow), 0);
    model_reset();
    rd_en = 1'b0; loop_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 6b: clear with a write drops the write and empties the FIFO
    cycle(0, 1, 16'h0011, 0, 0);
    cycle(0, 1, 16'h0022, 0, 0);
    cycle(1, 1, 16'h0033, 0, 0);
    chk("clear_count", int'(count), 0);
    cycle(0, 0, 0, 1, 0);   // underflow after clear

    // 5: threshold sweep; af=4, ae=1 then af=0
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, DW'(16'h100 + i), 0, 0);
      chk($sformatf("ae_sweep[%0d]", i + 1), int'(almost_empty), int'(i + 1 <= 1));
      chk($sformatf("af_sweep[%0d]", i + 1), int'(almost_full), int'(i + 1 >= 4));
    end
    af_thr = 3'd0;
    ae_thr = 3'd3;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 0);
      chk("af_disabled", int'(almost_full), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
